// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front-panel and controller blocks:
// keypad width, default debounce depth and the keypad FSM state encoding.
package microwave_pkg;

    localparam int KEYPAD_W            = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } kp_state_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser followed by a saturating
// debounce counter. The output only moves after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it; any agreeing sample clears the count.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 3,
    parameter int   CNT_W           = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; flops come out of reset at the inactive level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count disagreeing samples; the count never exceeds DEBOUNCE_CYCLES-1,
    // so it cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= RESET_VAL;
            cnt    <= '0;
        end else if (sync_p1 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/keypad_conditioner.sv
// Front-panel input conditioner for the microwave controller. The keypad is
// synchronised and run through a press/release FSM so the controller only
// ever sees one stable key or none; buttons and door use debounce_bit.
// Optional feature macro: KEYPAD_PULSE_EN -- keypad reports each press as a
// single-cycle pulse instead of a level held for the duration of the press.
module keypad_conditioner
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [KEYPAD_W-1:0] raw_keypad,
    input  logic                raw_startn,
    input  logic                raw_stopn,
    input  logic                raw_clearn,
    input  logic                raw_door_closed,
    output logic [KEYPAD_W-1:0] keypad,
    output logic                startn,
    output logic                stopn,
    output logic                clearn,
    output logic                door_closed
);

`ifdef KEYPAD_PULSE_EN
    localparam bit PULSE_MODE = 1'b1;
`else
    localparam bit PULSE_MODE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic is_onehot(input logic [KEYPAD_W-1:0] v);
        return (v != '0) && ((v & (v - KEYPAD_W'(1))) == '0);
    endfunction

    logic [KEYPAD_W-1:0] kp_sync_p0;
    logic [KEYPAD_W-1:0] kp_s;
    kp_state_t           state, state_nx;
    logic [KEYPAD_W-1:0] code, code_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [KEYPAD_W-1:0] keypad_nx;

    // Two-stage keypad synchroniser ahead of the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            kp_sync_p0 <= '0;
            kp_s       <= '0;
        end else begin
            kp_sync_p0 <= raw_keypad;
            kp_s       <= kp_sync_p0;
        end
    end

    // FSM state, captured code, counter and registered keypad output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            code   <= '0;
            cnt    <= '0;
            keypad <= '0;
        end else begin
            state  <= state_nx;
            code   <= code_nx;
            cnt    <= cnt_nx;
            keypad <= keypad_nx;
        end
    end

    // Next-state logic; a new key can only be accepted from IDLE, so the
    // output never jumps straight from one non-zero code to another.
    always_comb begin
        state_nx  = state;
        code_nx   = code;
        cnt_nx    = cnt;
        keypad_nx = '0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (is_onehot(kp_s)) begin
                    state_nx = PRESS_WAIT;
                    code_nx  = kp_s;
                    cnt_nx   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (kp_s == code) begin
                    if (cnt == CNT_LAST) begin
                        state_nx  = PRESSED;
                        cnt_nx    = '0;
                        keypad_nx = code;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            PRESSED: begin
                keypad_nx = PULSE_MODE ? '0 : code;
                cnt_nx    = '0;
                if (kp_s != code) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                keypad_nx = PULSE_MODE ? '0 : code;
                if (kp_s == code) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    keypad_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RESET_VAL(1'b1))
        u_start (.clock(clock), .reset(reset), .raw(raw_startn), .stable(startn));

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RESET_VAL(1'b1))
        u_stop (.clock(clock), .reset(reset), .raw(raw_stopn), .stable(stopn));

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RESET_VAL(1'b1))
        u_clear (.clock(clock), .reset(reset), .raw(raw_clearn), .stable(clearn));

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RESET_VAL(1'b0))
        u_door (.clock(clock), .reset(reset), .raw(raw_door_closed), .stable(door_closed));

endmodule
